// File: rtl/cmp8_pkg.sv
// rtl/cmp8_pkg.sv - shared constants and state encoding for the 8-bit compare sequencer
package cmp8_pkg;

   localparam int CMP_W     = 8;
   localparam int HIT_CNT_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SCAN = 2'd1;
   localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/eq8_cmp.sv
// rtl/eq8_cmp.sv - combinational 8-bit equality comparator
module eq8_cmp
   import cmp8_pkg::*;
(
   input  logic [CMP_W-1:0] a,
   input  logic [CMP_W-1:0] b,
   output logic             eq
);

   // Equal when no bit position differs.
   assign eq = ~|(a ^ b);

endmodule

// File: rtl/cmp8_scan_ctrl.sv
// rtl/cmp8_scan_ctrl.sv - table search sequencer time-sharing one eq8_cmp
module cmp8_scan_ctrl
   import cmp8_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 8,
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 clear_all,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DATA_W-1:0]    req_key,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_hit,
   output logic [IDX_W-1:0]     rsp_idx,
   output logic                 busy,
   output logic [HIT_CNT_W-1:0] hit_count
);

   state_t              state;
   logic [DATA_W-1:0]   tbl [DEPTH];
   logic [DEPTH-1:0]    vld;
   logic [DATA_W-1:0]   key_q;
   logic [IDX_W-1:0]    scan_idx;
   logic                eq;
   logic                match;
   logic                last_idx;
   logic                wr_in_range;

   assign wr_in_range = (int'(wr_idx) < DEPTH);
   assign last_idx    = (scan_idx == IDX_W'(DEPTH - 1));
   assign match       = eq && vld[scan_idx];

   assign req_ready = (state == ST_IDLE) && rst_n;
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   eq8_cmp u_cmp (
      .a  (tbl[scan_idx]),
      .b  (key_q),
      .eq (eq)
   );

   // Table bytes: written in any state; a compare this cycle still sees the old byte.
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         tbl[wr_idx] <= wr_data;
      end
   end

   // Valid bits: bulk clear beats a same-cycle write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= '0;
      end else if (clear_all) begin
         vld <= '0;
      end else if (wr_en && wr_in_range) begin
         vld[wr_idx] <= 1'b1;
      end
   end

   // Sequencer: accept key, walk the table from index 0, hold result until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         key_q    <= '0;
         scan_idx <= '0;
         rsp_hit  <= 1'b0;
         rsp_idx  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  key_q    <= req_key;
                  scan_idx <= '0;
                  state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (match) begin
                  rsp_hit <= 1'b1;
                  rsp_idx <= scan_idx;
                  state   <= ST_RESP;
               end else if (last_idx) begin
                  rsp_hit <= 1'b0;
                  rsp_idx <= '0;
                  state   <= ST_RESP;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Hit statistics: one per accepted hit response, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_count <= '0;
      end else if ((state == ST_RESP) && rsp_ready && rsp_hit && (hit_count != '1)) begin
         hit_count <= hit_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cmp8_scan_ctrl.sv
// tb/tb_cmp8_scan_ctrl.sv - self-checking bench for cmp8_scan_ctrl
module tb_cmp8_scan_ctrl;

   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [7:0]        wr_data;
   logic              clear_all;
   logic              req_valid;
   logic              req_ready;
   logic [7:0]        req_key;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_hit;
   logic [IDX_W-1:0]  rsp_idx;
   logic              busy;
   logic [15:0]       hit_count;

   always #5 clk = ~clk;

   cmp8_scan_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .clear_all (clear_all),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_key   (req_key),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_idx   (rsp_idx),
      .busy      (busy),
      .hit_count (hit_count)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] m_data [DEPTH];
   bit         m_vld  [DEPTH];
   int         m_hc;

   typedef struct {
      logic [7:0] key;
      int         hit;
      int         idx;
      int         cyc;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_idx  = idx[IDX_W-1:0];
      wr_data = d;
      step();
      wr_en = 1'b0;
      m_data[idx] = d;
      m_vld[idx]  = 1'b1;
   endtask

   task automatic clr();
      clear_all = 1'b1;
      step();
      clear_all = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
   endtask

   // Lowest valid entry equal to the key; latency counted in cycles from accept.
   task automatic ref_search(input logic [7:0] key, output int hit, output int idx, output int cyc);
      hit = 0;
      idx = 0;
      cyc = DEPTH + 1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m_vld[i] && m_data[i] == key) begin
            hit = 1;
            idx = i;
            cyc = i + 2;
         end
      end
   endtask

   task automatic accept(input logic [7:0] key, input logic rr);
      check("req_ready_before_accept", int'(req_ready), 1);
      req_valid = 1'b1;
      req_key   = key;
      rsp_ready = rr;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int hit, output int idx, output int cyc);
      int n;
      n = 0;
      while (!rsp_valid && n < DEPTH + 20) begin
         step();
         n++;
      end
      if (!rsp_valid) check("rsp_timeout", 0, 1);
      hit = int'(rsp_hit);
      idx = int'(rsp_idx);
      cyc = n + 1;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      step();
      check("busy_after_handshake", int'(busy), 0);
      check("rsp_valid_after_handshake", int'(rsp_valid), 0);
   endtask

   task automatic model_search(input string tag, input logic [7:0] key);
      int h, i, c, eh, ei, ec;
      ref_search(key, eh, ei, ec);
      accept(key, 1'b1);
      wait_rsp(h, i, c);
      check($sformatf("%s_hit key=%0h", tag, key), h, eh);
      check($sformatf("%s_idx key=%0h", tag, key), i, ei);
      check($sformatf("%s_cyc key=%0h", tag, key), c, ec);
      finish_rsp();
      if (eh != 0 && m_hc < 65535) m_hc++;
      check($sformatf("%s_hit_count", tag), int'(hit_count), m_hc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, i, c;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = '0;
      wr_data   = '0;
      clear_all = 1'b0;
      req_valid = 1'b0;
      req_key   = '0;
      rsp_ready = 1'b0;
      m_hc      = 0;
      for (int k = 0; k < DEPTH; k++) begin
         m_data[k] = '0;
         m_vld[k]  = 1'b0;
      end

      vecs[0] = '{8'h13, 1, 3, 5};
      vecs[1] = '{8'hAA, 0, 0, 17};
      vecs[2] = '{8'h10, 1, 0, 2};
      vecs[3] = '{8'h1F, 1, 15, 17};
      vecs[4] = '{8'h1A, 1, 10, 12};

      step();
      step();
      check("reset_req_ready_in_reset", int'(req_ready), 0);
      rst_n = 1'b1;
      #1;
      check("reset_busy", int'(busy), 0);
      check("reset_req_ready", int'(req_ready), 1);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_rsp_hit", int'(rsp_hit), 0);
      check("reset_rsp_idx", int'(rsp_idx), 0);
      check("reset_hit_count", int'(hit_count), 0);

      // Table-driven searches over entries 0x10..0x1F
      for (int k = 0; k < DEPTH; k++) wr(k, 8'h10 + 8'(k));
      for (int v = 0; v < 5; v++) begin
         accept(vecs[v].key, 1'b1);
         wait_rsp(h, i, c);
         check($sformatf("vec%0d_hit", v), h, vecs[v].hit);
         check($sformatf("vec%0d_idx", v), i, vecs[v].idx);
         check($sformatf("vec%0d_cycle", v), c, vecs[v].cyc);
         finish_rsp();
         if (vecs[v].hit != 0) m_hc++;
         check($sformatf("vec%0d_hit_count", v), int'(hit_count), m_hc);
      end

      // Duplicates resolve to the lowest index
      wr(2, 8'h55);
      wr(9, 8'h55);
      accept(8'h55, 1'b1);
      wait_rsp(h, i, c);
      check("dup_hit", h, 1);
      check("dup_idx", i, 2);
      finish_rsp();
      m_hc++;

      // clear_all wins over a same-cycle write
      clear_all = 1'b1;
      wr_en     = 1'b1;
      wr_idx    = 4'd2;
      wr_data   = 8'h55;
      step();
      clear_all = 1'b0;
      wr_en     = 1'b0;
      for (int k = 0; k < DEPTH; k++) m_vld[k] = 1'b0;
      m_data[2] = 8'h55;
      accept(8'h55, 1'b1);
      wait_rsp(h, i, c);
      check("clear_wins_hit", h, 0);
      check("clear_wins_idx", i, 0);
      check("clear_wins_cycle", c, DEPTH + 1);
      finish_rsp();

      // Backpressure: response held stable, further request ignored until after handshake
      wr(4, 8'h44);
      accept(8'h44, 1'b0);
      wait_rsp(h, i, c);
      check("bp_first_cycle", c, 6);
      req_valid = 1'b1;
      req_key   = 8'h44;
      for (int k = 0; k < 10; k++) begin
         step();
         check("bp_rsp_valid", int'(rsp_valid), 1);
         check("bp_rsp_hit", int'(rsp_hit), 1);
         check("bp_rsp_idx", int'(rsp_idx), 4);
         check("bp_req_ready", int'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      step();
      m_hc++;
      check("bp_busy_after_hs", int'(busy), 0);
      check("bp_req_ready_after_hs", int'(req_ready), 1);
      check("bp_hit_count", int'(hit_count), m_hc);
      step();
      req_valid = 1'b0;
      check("bp_next_accepted", int'(busy), 1);
      wait_rsp(h, i, c);
      check("bp_second_idx", i, 4);
      check("bp_second_cycle", c, 6);
      finish_rsp();
      m_hc++;

      // Write during scan lands ahead of the scan pointer -> hit
      clr();
      accept(8'h77, 1'b1);
      repeat (5) step();
      wr_en   = 1'b1;
      wr_idx  = 4'd8;
      wr_data = 8'h77;
      step();
      wr_en = 1'b0;
      m_data[8] = 8'h77;
      m_vld[8]  = 1'b1;
      wait_rsp(h, i, c);
      check("wds_ahead_hit", h, 1);
      check("wds_ahead_idx", i, 8);
      finish_rsp();
      m_hc++;

      // Same write on the edge leaving idx 8 is not seen by that compare -> miss
      wr(8, 8'h18);
      accept(8'h77, 1'b1);
      repeat (8) step();
      wr_en   = 1'b1;
      wr_idx  = 4'd8;
      wr_data = 8'h77;
      step();
      wr_en = 1'b0;
      m_data[8] = 8'h77;
      wait_rsp(h, i, c);
      check("wds_late_hit", h, 0);
      check("wds_late_idx", i, 0);
      finish_rsp();

      // Reset in the middle of a scan
      wr(0, 8'h10);
      accept(8'hEE, 1'b1);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < DEPTH; k++) m_vld[k] = 1'b0;
      m_hc = 0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_req_ready", int'(req_ready), 1);
      check("midrst_rsp_valid", int'(rsp_valid), 0);
      check("midrst_hit_count", int'(hit_count), 0);
      model_search("midrst_search", 8'h10);

      // Randomized traffic against the reference model
      for (int it = 0; it < 30; it++) begin
         int nw;
         nw = int'($urandom_range(0, 3));
         for (int w = 0; w < nw; w++) begin
            wr(int'($urandom_range(0, DEPTH - 1)), 8'h60 + 8'($urandom_range(0, 7)));
         end
         if ($urandom_range(0, 9) == 0) clr();
         model_search("rand", 8'h60 + 8'($urandom_range(0, 8)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp8_scan_ctrl.md
Name: cmp8_scan_ctrl

Overview:
- Sequencer that time-shares a single 8-bit equality comparator (sub-module eq8_cmp) to search a small register table of stored bytes for a requested key.
- Table written through a simple write port; searches accepted through a valid/ready request channel, answered on a valid/ready response channel with hit flag and lowest matching index.
- Sits beside the arith comparator library as the control/scheduling layer for the 8-bit comparator.

Parameters:
- DEPTH, 16, number of table entries (2..256)
- DATA_W, 8, entry/key width; fixed at 8 (eq8_cmp width)
- IDX_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  write table entry this cycle
- wr_idx  in  IDX_W  entry index to write
- wr_data  in  8  byte to store; entry valid bit set on write
- clear_all  in  1  clear all entry valid bits
- req_valid  in  1  search request valid
- req_ready  out  1  block can accept a request
- req_key  in  8  key to search
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_hit  out  1  1 = match found
- rsp_idx  out  IDX_W  lowest matching index (0 on miss)
- busy  out  1  FSM not in IDLE
- hit_count  out  16  saturating count of responses with hit=1

Behaviour:
- Reset (rst_n=0 at a rising edge): FSM=IDLE, all valid bits=0, rsp_valid=0, rsp_hit=0, rsp_idx=0, hit_count=0, scan index=0. Table data bytes need not be reset. Reset mid-scan or mid-response aborts; pending response is dropped.
- req_ready = (state==IDLE) && rst_n; combinational from state only, never from req_valid.
- FSM states: IDLE, SCAN, RESP.
- IDLE: on req_valid && req_ready, latch req_key into key_q, scan index=0 -> SCAN.
- SCAN: each cycle eq8_cmp compares table[idx] with key_q; match = eq && valid[idx].
  - match -> rsp_hit=1, rsp_idx=idx -> RESP.
  - no match and idx==DEPTH-1 -> rsp_hit=0, rsp_idx=0 -> RESP.
  - otherwise idx <- idx+1, stay in SCAN. Index never wraps.
- RESP: rsp_valid=1; rsp_hit/rsp_idx stable until rsp_valid && rsp_ready, then -> IDLE (rsp_valid=0 next cycle). Next request accepted no earlier than the cycle after the response handshake.
- Latency from the request-accept edge: match at index k -> rsp_valid high from cycle k+2; miss -> rsp_valid high from cycle DEPTH+1.
- Table writes are accepted in every state. A write updates the entry at the edge. A compare in a given cycle sees the table contents present in that cycle; a same-edge write is not visible to that compare.
- clear_all has priority over a same-cycle wr_en. Both take effect at the edge.
- An entry with valid=0 never matches, even if its stale data equals the key.
- hit_count increments by 1 at each response handshake with rsp_hit=1 and saturates at 0xFFFF.
- busy = (state != IDLE).

Decomposition:
- Shared package cmp8_pkg: state enum (IDLE, SCAN, RESP), CMP_W=8 constant, HIT_CNT_W=16 constant.
- One sub-module: eq8_cmp (ports a[7:0], b[7:0], eq). Purely combinational XOR/NOR equality, instantiated once.
- Controller, table registers and counter live in cmp8_scan_ctrl.

Test Plan:
- Write entries 0..15 = 0x10..0x1F; request key 0x13, rsp_ready=1 -> rsp_valid at cycle 5 after accept, rsp_hit=1, rsp_idx=3; hit_count=1.
- Request key 0xAA (absent), DEPTH=16 -> rsp_valid at cycle 17, rsp_hit=0, rsp_idx=0; hit_count unchanged.
- Duplicates: entries 2 and 9 = 0x55 -> rsp_idx=2. Then clear_all and wr_en to idx 2 in the same cycle, request 0x55 -> miss (clear wins).
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_hit, rsp_idx stable; req_ready=0 throughout; new req_valid ignored until the cycle after the handshake.
- Write during scan: request 0x77 (absent); at scan cycle for idx 5 write idx 8=0x77 -> rsp_hit=1, rsp_idx=8. Same write issued at the edge leaving idx 8 -> miss.
- Drop rst_n for one cycle mid-SCAN -> next cycle: busy=0, req_ready=1, rsp_valid=0, hit_count=0, all entries invalid (search 0x10 misses).
